// File: rtl/pipe_skid_latch.sv
// Two-entry pipeline latch (main + skid) with flush, NOP bubble insertion and a saturating stall counter.
// Latency 1 cycle; in_ready depends only on registered state, so there is no combinational path from out_ready.
module pipe_skid_latch #(
  parameter int                 PC_W      = 32,
  parameter int                 INSTR_W   = 32,
  parameter logic [INSTR_W-1:0] NOP_INSTR = INSTR_W'(32'h00000013),
  parameter int                 CNT_W     = 16
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [PC_W-1:0]    in_pc,
  input  logic [INSTR_W-1:0] in_instr,
  input  logic               flush,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [PC_W-1:0]    out_pc,
  output logic [INSTR_W-1:0] out_instr,
  output logic [1:0]         occupancy,
  output logic [CNT_W-1:0]   stall_cnt
);

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    FULL  = 2'd2
  } state_t;

  state_t             state;
  logic [PC_W-1:0]    main_pc;
  logic [INSTR_W-1:0] main_instr;
  logic [PC_W-1:0]    skid_pc;
  logic [INSTR_W-1:0] skid_instr;
  logic               acc;
  logic               dq;

  // Handshake outputs decode straight from the state flops.
  assign out_valid = (state != EMPTY);
  assign in_ready  = (state != FULL);
  assign occupancy = state;
  assign out_pc    = main_pc;
  assign out_instr = main_instr;

  assign acc = in_valid & in_ready;
  assign dq  = out_valid & out_ready;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= EMPTY;
      main_pc    <= '0;
      main_instr <= NOP_INSTR;
      skid_pc    <= '0;
      skid_instr <= '0;
      stall_cnt  <= '0;
    end else begin
      if (out_valid && !out_ready && !flush && (stall_cnt != {CNT_W{1'b1}}))
        stall_cnt <= stall_cnt + 1'b1;

      if (flush) begin
        // Main pc is left alone; only the instruction becomes a bubble.
        state      <= EMPTY;
        main_instr <= NOP_INSTR;
      end else begin
        case (state)
          EMPTY: begin
            if (acc) begin
              main_pc    <= in_pc;
              main_instr <= in_instr;
              state      <= ONE;
            end
          end
          ONE: begin
            if (acc && !dq) begin
              skid_pc    <= in_pc;
              skid_instr <= in_instr;
              state      <= FULL;
            end else if (acc && dq) begin
              main_pc    <= in_pc;
              main_instr <= in_instr;
            end else if (dq) begin
              main_instr <= NOP_INSTR;
              state      <= EMPTY;
            end
          end
          FULL: begin
            if (dq) begin
              main_pc    <= skid_pc;
              main_instr <= skid_instr;
              state      <= ONE;
            end
          end
          default: begin
            main_instr <= NOP_INSTR;
            state      <= EMPTY;
          end
        endcase
      end
    end
  end

endmodule
